// File: rtl/ysyx_22040127_mem_stage.sv
// MEM pipeline stage: latches the EX bundle, runs data-memory loads/stores over a
// req/gnt/rvalid port, extends load data and emits the {reg_wen, rd, wdata} bundle.
module ysyx_22040127_mem_stage #(
   parameter int IN_W  = 139,
   parameter int OUT_W = 70
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_to_mem_valid,
   input  logic [IN_W-1:0]  ex_to_mem_bus,
   output logic             mem_allowin,
   output logic             mem_to_wb_valid,
   input  logic             wb_allowin,
   output logic [OUT_W-1:0] mem_to_wb_bus,
   output logic             mem_misalign,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [63:0]      dmem_addr,
   output logic [63:0]      dmem_wdata,
   output logic [7:0]       dmem_wmask,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic [63:0]      dmem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_e;

   state_e          state_q;
   logic            req_q;
   logic            mem_valid_q;
   logic [IN_W-1:0] bus_q;
   logic [63:0]     load_data_q;

   // Fields of the resident bundle
   logic        reg_wen;
   logic [4:0]  rd;
   logic [63:0] alu_result;
   logic [63:0] store_data;
   logic        is_load;
   logic        is_store;
   logic [1:0]  size;
   logic        is_unsigned;

   assign reg_wen     = bus_q[138];
   assign rd          = bus_q[137:133];
   assign alu_result  = bus_q[132:69];
   assign store_data  = bus_q[68:5];
   assign is_load     = bus_q[4];
   assign is_store    = bus_q[3];
   assign size        = bus_q[2:1];
   assign is_unsigned = bus_q[0];

   // An access is misaligned when the byte offset is not a multiple of its size.
   function automatic logic offset_misaligned(input logic [2:0] off, input logic [1:0] sz);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   logic misalign;
   logic mem_op;
   logic in_mem_op;
   logic mem_ready_go;
   logic accept;

   assign misalign  = (is_load || is_store) && offset_misaligned(alu_result[2:0], size);
   assign mem_op    = (is_load || is_store) && !misalign;
   // Incoming bundle decides whether the FSM must launch a request on acceptance.
   assign in_mem_op = (ex_to_mem_bus[4] || ex_to_mem_bus[3]) &&
                      !offset_misaligned(ex_to_mem_bus[71:69], ex_to_mem_bus[2:1]);

   assign mem_ready_go    = !mem_op || (state_q == DONE);
   assign mem_allowin     = !mem_valid_q || (mem_ready_go && wb_allowin);
   assign mem_to_wb_valid = mem_valid_q && mem_ready_go;
   assign accept          = ex_to_mem_valid && mem_allowin;
   assign mem_misalign    = mem_to_wb_valid && misalign;

   // Memory port is driven entirely from the latched bundle, so it is stable until gnt.
   logic [7:0] size_mask;
   always_comb begin
      // NOTE: every branch of a combinational case must assign, or a latch is inferred;
      // the default supplies the fall-through value.
      size_mask = 8'hFF;
      case (size)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   assign dmem_req   = req_q;
   assign dmem_we    = is_store;
   assign dmem_addr  = {alu_result[63:3], 3'b000};
   assign dmem_wdata = store_data << {alu_result[2:0], 3'b000};
   assign dmem_wmask = size_mask << alu_result[2:0];

   // Align the returned doubleword and sign/zero-extend to 64 bits.
   logic [63:0] shifted;
   logic [63:0] load_ext;
   always_comb begin
      shifted  = dmem_rdata >> {alu_result[2:0], 3'b000};
      load_ext = shifted;
      case (size)
         2'd0:    load_ext = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1:    load_ext = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2:    load_ext = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   // Writeback bundle: stores and misaligned accesses never write the register file.
   logic        out_wen;
   logic [63:0] out_wdata;
   assign out_wen       = reg_wen && !is_store && !misalign;
   assign out_wdata     = (is_load && !misalign) ? load_data_q : alu_result;
   assign mem_to_wb_bus = {out_wen, rd, out_wdata};

   // Stage occupancy and bundle register, updated whenever the stage can take a new bundle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples
         // pre-edge values regardless of statement order.
         mem_valid_q <= 1'b0;
         bus_q       <= '0;
      end else if (mem_allowin) begin
         mem_valid_q <= ex_to_mem_valid;
         if (ex_to_mem_valid) bus_q <= ex_to_mem_bus;
      end
   end

   // Memory access FSM with registered request and load-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         // NOTE: the load-data register is reset too, so a stale value can never reach
         // writeback after a mid-transaction reset.
         load_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && in_mem_op) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  req_q   <= 1'b0;
                  state_q <= is_store ? DONE : RESP;
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  load_data_q <= load_ext;
                  state_q     <= DONE;
               end
            end
            default: begin
               if (wb_allowin) begin
                  if (accept && in_mem_op) begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule
